// File: rtl/spi_ram_ctrl.sv
// Purpose : command-decoding single-port RAM behind an SPI slave (address-before-data ordering, error flagging)
// Latency : 1 cycle from a rx_valid word to dout/tx_valid/cmd_err
// Backpr. : none; a word is accepted on every rx_valid cycle, including back-to-back cycles
//
// Ports:
//   clk       in   1   single clock, posedge
//   rst       in   1   asynchronous active-high reset
//   din       in   10  command word: din[9:8] = command, din[7:0] = payload
//   rx_valid  in   1   din qualifier, one pulse per word
//   dout      out  8   read data, held until the next completed read
//   tx_valid  out  1   one-cycle pulse per completed read
//   cmd_err   out  1   one-cycle pulse on an out-of-order or out-of-range command
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  cmd_e                 cmd;
  logic [ADDR_SIZE-1:0] addr_pl;
  logic [7:0]           data_pl;

  assign cmd     = cmd_e'(din[9:8]);
  // Payload bits above ADDR_SIZE carry no address information.
  assign addr_pl = din[ADDR_SIZE-1:0];
  assign data_pl = din[7:0];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_ok_q, wr_ok_d;
  logic                 rd_ok_q, rd_ok_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 cmd_err_q, cmd_err_d;

  logic [7:0] mem [MEM_DEPTH];
  logic       mem_we;
  logic [7:0] mem_rd_dat;
  logic       wr_in_range;
  logic       rd_in_range;

  // Addresses may legally hold values beyond the array; range is checked at
  // data time so an out-of-range address is still "set" and can be flagged.
  assign wr_in_range = 32'(wr_addr_q) < MEM_DEPTH;
  assign rd_in_range = 32'(rd_addr_q) < MEM_DEPTH;
  assign mem_rd_dat  = mem[rd_addr_q];

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_ok_d    = wr_ok_q;
    rd_ok_d    = rd_ok_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;

    if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_d = addr_pl;
          wr_ok_d   = 1'b1;
        end
        CMD_WR_DATA: begin
          // wr_ok stays set so consecutive data words hit the same address.
          if (wr_ok_q && wr_in_range) begin
            mem_we = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d = addr_pl;
          rd_ok_d   = 1'b1;
        end
        CMD_RD_DATA: begin
          if (rd_ok_q) begin
            // One read per address; an out-of-range read still completes
            // (with zero data) so the slave gets a byte to shift out.
            rd_ok_d    = 1'b0;
            tx_valid_d = 1'b1;
            if (rd_in_range) begin
              dout_d = mem_rd_dat;
            end else begin
              dout_d    = 8'h00;
              cmd_err_d = 1'b1;
            end
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: begin
          cmd_err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_ok_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
      dout_q     <= 8'h00;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_ok_q    <= wr_ok_d;
      rd_ok_q    <= rd_ok_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Array is deliberately outside the reset domain: contents survive rst.
  // A write lands at this edge, so a read on the following cycle sees it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q] <= data_pl;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl (MEM_DEPTH=200 so the out-of-range path is reachable).
// Stimulus words feed a reference model that pushes the expected output into a
// scoreboard queue; each test pops and compares one cycle after the word.
module tb_spi_ram_ctrl;

  localparam int DEPTH = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  typedef struct packed {
    logic       tx;
    logic       err;
    logic [7:0] d;
    logic       d_known;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_wa, m_ra, m_dout;
  bit         m_wok, m_rok, m_dout_known;

  function automatic void model_word(input logic [1:0] cmd, input logic [7:0] pl);
    exp_t e;
    e.tx  = 1'b0;
    e.err = 1'b0;
    case (cmd)
      2'b00: begin m_wa = pl; m_wok = 1'b1; end
      2'b01: begin
        if (m_wok && (int'(m_wa) < DEPTH)) begin
          m_mem[m_wa]   = pl;
          m_known[m_wa] = 1'b1;
        end else begin
          e.err = 1'b1;
        end
      end
      2'b10: begin m_ra = pl; m_rok = 1'b1; end
      default: begin
        if (!m_rok) begin
          e.err = 1'b1;
        end else begin
          e.tx  = 1'b1;
          m_rok = 1'b0;
          if (int'(m_ra) < DEPTH) begin
            m_dout       = m_mem[m_ra];
            m_dout_known = m_known[m_ra];
          end else begin
            m_dout       = 8'h00;
            m_dout_known = 1'b1;
            e.err        = 1'b1;
          end
        end
      end
    endcase
    e.d       = m_dout;
    e.d_known = m_dout_known;
    sb.push_back(e);
  endfunction

  // Drive one word at negedge (rx_valid stays high for back-to-back use),
  // then step to just after the next posedge where its response is visible.
  task automatic drive(input logic [1:0] cmd, input logic [7:0] pl);
    @(negedge clk);
    din      = {cmd, pl};
    rx_valid = 1'b1;
    model_word(cmd, pl);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      din      = $urandom_range(0, 1023);
      @(posedge clk);
      #1;
      checks++;
      if (tx_valid !== 1'b0 || cmd_err !== 1'b0 || (m_dout_known && dout !== m_dout)) begin
        errors++;
        $display("FAIL %s idle%0d: tx=%b err=%b dout=%h, required tx=0 err=0 dout=%h",
                 tag, i, tx_valid, cmd_err, dout, m_dout);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    m_wa = 8'h00; m_ra = 8'h00; m_wok = 1'b0; m_rok = 1'b0;
    m_dout = 8'h00; m_dout_known = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_words(input logic [9:0] words [], input string tag);
    exp_t e;
    foreach (words[i]) begin
      drive(words[i][9:8], words[i][7:0]);
      e = sb.pop_front();
      checks++;
      if (tx_valid !== e.tx || cmd_err !== e.err || (e.d_known && dout !== e.d)) begin
        errors++;
        $display("FAIL %s word%0d (%h): tx=%b err=%b dout=%h, required tx=%b err=%b dout=%h",
                 tag, i, words[i], tx_valid, cmd_err, dout, e.tx, e.err, e.d);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b1;
    din = 10'h3FF;
    #1;
    checks++;
    if (dout !== 8'h00 || tx_valid !== 1'b0 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: dout=%h tx=%b err=%b, required 00/0/0", dout, tx_valid, cmd_err);
    end
    do_reset();
    idle(1, "reset");
  endtask

  task automatic test_write_read();
    logic [9:0] w [] = '{10'h010, 10'h1A5, 10'h210, 10'h300};
    run_words(w, "wr_rd");
    checks++;
    if (dout !== 8'hA5 || tx_valid !== 1'b1 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_const: dout=%h tx=%b err=%b, required A5/1/0", dout, tx_valid, cmd_err);
    end
    idle(2, "wr_rd");
  endtask

  task automatic test_order_err();
    logic [9:0] w [] = '{10'h133, 10'h300};
    do_reset();
    run_words(w, "order");
    checks++;
    if (dout !== 8'h00 || tx_valid !== 1'b0 || cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL order_const: dout=%h tx=%b err=%b, required 00/0/1", dout, tx_valid, cmd_err);
    end
    idle(1, "order");
  endtask

  task automatic test_double_read();
    logic [9:0] w [] = '{10'h210, 10'h300, 10'h300};
    run_words(w, "dbl_rd");
    checks++;
    if (dout !== 8'hA5 || tx_valid !== 1'b0 || cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL dbl_rd_const: dout=%h tx=%b err=%b, required A5/0/1", dout, tx_valid, cmd_err);
    end
    idle(1, "dbl_rd");
  endtask

  task automatic test_range();
    logic [9:0] w [] = '{10'h0C8, 10'h177, 10'h2C8, 10'h300};
    run_words(w, "range");
    checks++;
    if (dout !== 8'h00 || tx_valid !== 1'b1 || cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL range_const: dout=%h tx=%b err=%b, required 00/1/1", dout, tx_valid, cmd_err);
    end
    idle(1, "range");
  endtask

  task automatic test_back_to_back();
    logic [9:0] w [] = '{10'h001, 10'h15A, 10'h201, 10'h300};
    run_words(w, "b2b");
    checks++;
    if (dout !== 8'h5A || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_const: dout=%h tx=%b, required 5A/1", dout, tx_valid);
    end
    idle(2, "b2b");
  endtask

  task automatic test_write_then_read_same();
    logic [9:0] w [] = '{10'h020, 10'h120, 10'h220, 10'h199, 10'h300, 10'h1C3, 10'h220, 10'h300};
    run_words(w, "wr_fwd");
    checks++;
    if (dout !== 8'hC3 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL wr_fwd_const: dout=%h tx=%b, required C3/1", dout, tx_valid);
    end
    idle(1, "wr_fwd");
  endtask

  task automatic test_reset_persist();
    logic [9:0] wa [] = '{10'h007, 10'h13C};
    logic [9:0] wb [] = '{10'h207, 10'h300};
    run_words(wa, "persist_wr");
    idle(2, "persist");
    do_reset();
    idle(1, "persist_rst");
    run_words(wb, "persist_rd");
    checks++;
    if (dout !== 8'h3C || tx_valid !== 1'b1 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL persist_const: dout=%h tx=%b err=%b, required 3C/1/0", dout, tx_valid, cmd_err);
    end
    idle(1, "persist");
  endtask

  task automatic test_random();
    logic [9:0] w [] = new[60];
    for (int i = 0; i < 60; i++) begin
      w[i] = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
      // Keep addresses on a small set so reads often hit written data.
      if (w[i][9:8] == 2'b00 || w[i][9:8] == 2'b10)
        w[i][7:0] = (i % 5 == 0) ? 8'hD0 : {5'b0, w[i][2:0]};
    end
    run_words(w, "random");
    idle(1, "random");
  endtask

  initial begin
    rst      = 1'b0;
    rx_valid = 1'b0;
    din      = 10'h000;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    m_dout = 8'h00; m_dout_known = 1'b1;

    test_reset();
    test_write_read();
    test_order_err();
    test_double_read();
    test_range();
    test_back_to_back();
    test_write_then_read_same();
    test_reset_persist();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
